// File: rtl/macro_sel_ctrl.sv
// ---------------------------------------------------------------------------
// macro_sel_ctrl
//
// Pad owner selector for the user-area test macros that share io_out/io_oeb.
// One macro at a time drives the pads, and its 'active' line is the only one
// asserted. An ownership change is break-before-make: the pads are tri-stated
// and every active line is dropped for a programmable guard interval before
// the new owner is connected.
//
// Register window (16 bytes at BASE_ADDR):
//   0x0 CTRL   [7] enable, [2:0] sel                          (RW)
//   0x4 STATUS [2:0] owner, [5:4] state, [8] busy,
//              [9] sel_err (W1C), [10] busy_err (W1C)
//   0x8 GUARD  [7:0] guard load, a write of 0 stores 1        (RW)
//   0xC SWCNT  [15:0] completed switches into ACTIVE, saturating; any write
//              clears it. Built only when SWITCH_COUNT_EN is defined,
//              otherwise it reads 0 and writes are acked and dropped.
//
// Ports:
//   wb_clk_i, wb_rst_ni      clock, asynchronous active-low reset
//   wbs_*                    Wishbone slave (single-cycle registered ack)
//   io_out_m, io_oeb_m       packed macro pad outputs, macro k at [k*IO_W +: IO_W]
//   io_out, io_oeb           pads of the current owner (io_oeb all 1 when none)
//   active                   one-hot owner enable
//   switch_done              one-cycle pulse when a switch sequence completes
//
// Optional feature macro: SWITCH_COUNT_EN
// ---------------------------------------------------------------------------
module macro_sel_ctrl #(
    parameter int          NUM_MACROS   = 4,
    parameter int          IO_W         = 38,
    parameter int          GUARD_CYCLES = 4,
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_ni,
    input  logic                          wbs_stb_i,
    input  logic                          wbs_cyc_i,
    input  logic                          wbs_we_i,
    input  logic [3:0]                    wbs_sel_i,
    input  logic [31:0]                   wbs_dat_i,
    input  logic [31:0]                   wbs_adr_i,
    output logic                          wbs_ack_o,
    output logic [31:0]                   wbs_dat_o,
    input  logic [NUM_MACROS*IO_W-1:0]    io_out_m,
    input  logic [NUM_MACROS*IO_W-1:0]    io_oeb_m,
    output logic [IO_W-1:0]               io_out,
    output logic [IO_W-1:0]               io_oeb,
    output logic [NUM_MACROS-1:0]         active,
    output logic                          switch_done
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_GUARD  = 2'd3
    } state_t;

    localparam logic [3:0] NUM_M4    = 4'(NUM_MACROS);
    localparam logic [7:0] GUARD_RST = 8'(GUARD_CYCLES);

    state_t      state_q, state_d;
    logic [2:0]  owner_q, owner_d;
    logic [2:0]  target_q, target_d;
    logic        target_en_q, target_en_d;
    logic [7:0]  ctrl_q, ctrl_d;
    logic [7:0]  guard_load_q, guard_load_d;
    logic [7:0]  guard_cnt_q, guard_cnt_d;
    logic        sel_err_q, sel_err_d;
    logic        busy_err_q, busy_err_d;
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic        done_q, done_d;
`ifdef SWITCH_COUNT_EN
    logic [15:0] swcnt_q, swcnt_d;
`endif

    // Bus decode
    logic        hit, accept, wr, rd;
    logic [1:0]  off;
    logic        ctrl_wr, status_wr, guard_wr;
    logic        wr_en;
    logic [2:0]  wr_sel;
    logic        sel_bad, busy, ctrl_ok;
    logic        enter_active;
    logic [15:0] swcnt_rd;
    logic [31:0] rd_data;

    // Bits of the bus that no register uses
    logic unused_bits;
    assign unused_bits = ^{wbs_sel_i[3:1], wbs_dat_i[31:11], wbs_dat_i[8], wbs_adr_i[1:0]};

    assign hit       = wbs_stb_i && wbs_cyc_i && (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    // ack_q masks the still-asserted strobe of the cycle being acknowledged
    assign accept    = hit && !ack_q;
    assign wr        = accept && wbs_we_i;
    assign rd        = accept && !wbs_we_i;
    assign off       = wbs_adr_i[3:2];
    assign ctrl_wr   = wr && (off == 2'd0) && wbs_sel_i[0];
    assign status_wr = wr && (off == 2'd1);
    assign guard_wr  = wr && (off == 2'd2) && wbs_sel_i[0];
    assign wr_en     = wbs_dat_i[7];
    assign wr_sel    = wbs_dat_i[2:0];
    assign sel_bad   = ({1'b0, wr_sel} >= NUM_M4);
    assign busy      = (state_q == ST_DRAIN) || (state_q == ST_GUARD);
    assign ctrl_ok   = ctrl_wr && !busy && !sel_bad;

    // -----------------------------------------------------------------------
    // Next-state and register logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        target_d     = target_q;
        target_en_d  = target_en_q;
        ctrl_d       = ctrl_q;
        guard_load_d = guard_load_q;
        guard_cnt_d  = guard_cnt_q;
        done_d       = 1'b0;
        enter_active = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (ctrl_ok && wr_en) begin
                    target_d    = wr_sel;
                    target_en_d = 1'b1;
                    state_d     = ST_DRAIN;
                end
            end
            ST_ACTIVE: begin
                if (ctrl_ok) begin
                    if (wr_en && (wr_sel != owner_q)) begin
                        target_d    = wr_sel;
                        target_en_d = 1'b1;
                        state_d     = ST_DRAIN;
                    end else if (!wr_en) begin
                        target_en_d = 1'b0;
                        state_d     = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                guard_cnt_d = guard_load_q;
                state_d     = ST_GUARD;
            end
            ST_GUARD: begin
                // The cycle with count 1 is the last guard cycle
                if (guard_cnt_q <= 8'd1) begin
                    done_d = 1'b1;
                    if (target_en_q) begin
                        state_d      = ST_ACTIVE;
                        owner_d      = target_q;
                        enter_active = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    guard_cnt_d = guard_cnt_q - 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (ctrl_ok) begin
            ctrl_d = {wr_en, 4'b0000, wr_sel};
        end

        if (guard_wr) begin
            guard_load_d = (wbs_dat_i[7:0] == 8'd0) ? 8'd1 : wbs_dat_i[7:0];
        end

        // Clear first, then set, so a new error in the same cycle survives
        sel_err_d  = (sel_err_q  && !(status_wr && wbs_dat_i[9]))  || (ctrl_wr && sel_bad);
        busy_err_d = (busy_err_q && !(status_wr && wbs_dat_i[10])) || (ctrl_wr && busy);

`ifdef SWITCH_COUNT_EN
        swcnt_d = swcnt_q;
        if (wr && (off == 2'd3)) begin
            swcnt_d = 16'd0;
        end else if (enter_active && (swcnt_q != 16'hFFFF)) begin
            swcnt_d = swcnt_q + 16'd1;
        end
        swcnt_rd = swcnt_q;
`else
        swcnt_rd = 16'd0;
`endif

        unique case (off)
            2'd0:    rd_data = {24'd0, ctrl_q};
            2'd1:    rd_data = {21'd0, busy_err_q, sel_err_q, busy, 2'b00,
                                state_q, 1'b0, owner_q};
            2'd2:    rd_data = {24'd0, guard_load_q};
            default: rd_data = {16'd0, swcnt_rd};
        endcase

        ack_d = accept;
        dat_d = rd ? rd_data : 32'd0;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q      <= ST_IDLE;
            owner_q      <= 3'd0;
            target_q     <= 3'd0;
            target_en_q  <= 1'b0;
            ctrl_q       <= 8'd0;
            guard_load_q <= GUARD_RST;
            guard_cnt_q  <= 8'd0;
            sel_err_q    <= 1'b0;
            busy_err_q   <= 1'b0;
            ack_q        <= 1'b0;
            dat_q        <= 32'd0;
            done_q       <= 1'b0;
`ifdef SWITCH_COUNT_EN
            swcnt_q      <= 16'd0;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            target_q     <= target_d;
            target_en_q  <= target_en_d;
            ctrl_q       <= ctrl_d;
            guard_load_q <= guard_load_d;
            guard_cnt_q  <= guard_cnt_d;
            sel_err_q    <= sel_err_d;
            busy_err_q   <= busy_err_d;
            ack_q        <= ack_d;
            dat_q        <= dat_d;
            done_q       <= done_d;
`ifdef SWITCH_COUNT_EN
            swcnt_q      <= swcnt_d;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Pad mux: decoded straight from registered state/owner so the old owner
    // drops in the very cycle DRAIN is entered.
    // -----------------------------------------------------------------------
    logic [NUM_MACROS-1:0] active_w;

    generate
        for (genvar gi = 0; gi < NUM_MACROS; gi++) begin : g_active
            assign active_w[gi] = (state_q == ST_ACTIVE) && (owner_q == 3'(gi));
        end
    endgenerate

    logic [IO_W-1:0] mux_out;
    logic [IO_W-1:0] mux_drive;

    // AND-OR mux; with no owner selected nothing drives, so io_oeb is all 1
    always_comb begin
        mux_out   = '0;
        mux_drive = '0;
        for (int i = 0; i < NUM_MACROS; i++) begin
            if (active_w[i]) begin
                mux_out   = mux_out   | io_out_m[i*IO_W +: IO_W];
                mux_drive = mux_drive | ~io_oeb_m[i*IO_W +: IO_W];
            end
        end
    end

    assign io_out      = mux_out;
    assign io_oeb      = ~mux_drive;
    assign active      = active_w;
    assign switch_done = done_q;
    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = dat_q;

endmodule

// File: tb/tb_macro_sel_ctrl.sv
module tb_macro_sel_ctrl;

    localparam int NM   = 4;
    localparam int IO_W = 38;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] A_CTRL  = 32'h3000_0000;
    localparam logic [31:0] A_STAT  = 32'h3000_0004;
    localparam logic [31:0] A_GUARD = 32'h3000_0008;
    localparam logic [31:0] A_SWCNT = 32'h3000_000C;
    localparam logic [IO_W-1:0] OEB_ALL = '1;

`ifdef SWITCH_COUNT_EN
    localparam bit HAS_CNT = 1'b1;
`else
    localparam bit HAS_CNT = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   stb, cyc, we;
    logic [3:0]             sel;
    logic [31:0]            dat_i, adr;
    logic                   ack;
    logic [31:0]            dat_o;
    logic [NM*IO_W-1:0]     io_out_m, io_oeb_m;
    logic [IO_W-1:0]        io_out, io_oeb;
    logic [NM-1:0]          active;
    logic                   switch_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    macro_sel_ctrl #(
        .NUM_MACROS(NM), .IO_W(IO_W), .GUARD_CYCLES(4), .BASE_ADDR(BASE)
    ) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_dat_i(dat_i), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .io_out_m(io_out_m), .io_oeb_m(io_oeb_m),
        .io_out(io_out), .io_oeb(io_oeb), .active(active), .switch_done(switch_done)
    );

    // Macro k drives a recognisable pattern on each of its slices
    function automatic logic [IO_W-1:0] mk_out(input int k);
        return 38'h2A_1234_5670 + 38'(k);
    endfunction
    function automatic logic [IO_W-1:0] mk_oeb(input int k);
        return 38'h15_0F0F_0000 + 38'(k);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One Wishbone access; returns at the falling edge of the ack cycle
    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic exp_ack, output logic [31:0] rdat);
        @(posedge clk); #1;
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d; sel = 4'hF;
        @(posedge clk); #1;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(negedge clk);
        check("wb_ack", 64'(ack), 64'(exp_ack));
        rdat = dat_o;
        if (w || !exp_ack) check("wb_dat_idle", 64'(dat_o), 64'd0);
        $display("%s adr=%08h wdat=%08h rdat=%08h ack=%0d", w ? "WR" : "RD", a, d, dat_o, ack);
    endtask

    task automatic wb_wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r;
        wb_xfer(1'b1, a, d, 1'b1, r);
    endtask

    task automatic wb_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] r;
        wb_xfer(1'b0, a, 32'd0, 1'b1, r);
        check(tag, 64'(r), 64'(exp));
    endtask

    // Bounded wait for switch_done; checks latency (falling edges after the
    // ack cycle) and the resulting active vector
    task automatic wait_switch(input string tag, input int exp_lat, input logic [NM-1:0] exp_act);
        int n = 0;
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (switch_done) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_done"}, 64'(seen), 64'd1);
        check({tag, "_lat"}, 64'(n), 64'(exp_lat));
        check({tag, "_active"}, 64'(active), 64'(exp_act));
    endtask

    // Checks the guard gap: nothing active, pads released
    task automatic check_gap(input string tag);
        check({tag, "_gap_active"}, 64'(active), 64'd0);
        check({tag, "_gap_oeb"}, 64'(io_oeb), 64'(OEB_ALL));
        check({tag, "_gap_out"}, 64'(io_out), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
        dat_i = 32'd0; adr = 32'd0;
        for (int k = 0; k < NM; k++) begin
            io_out_m[k*IO_W +: IO_W] = mk_out(k);
            io_oeb_m[k*IO_W +: IO_W] = mk_oeb(k);
        end

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("rst_active", 64'(active), 64'd0);
        check("rst_oeb", 64'(io_oeb), 64'(OEB_ALL));
        check("rst_out", 64'(io_out), 64'd0);
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_done", 64'(switch_done), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        wb_rd("rst_status", A_STAT, 32'h0);
        wb_rd("rst_ctrl", A_CTRL, 32'h0);
        wb_rd("rst_guard", A_GUARD, 32'h4);
        wb_rd("rst_swcnt", A_SWCNT, 32'h0);

        // ---- address miss: no ack ----
        begin
            logic [31:0] r;
            wb_xfer(1'b1, 32'h3000_0010, 32'h81, 1'b0, r);
            wb_xfer(1'b0, 32'h2000_0004, 32'h0, 1'b0, r);
        end
        check("miss_active", 64'(active), 64'd0);

        // ---- IDLE -> macro 1, G=4: DRAIN T+1, GUARD T+2..T+5, active T+6 ----
        wb_wr(A_CTRL, 32'h81);
        check_gap("sw1_t1");
        check("sw1_t1_done", 64'(switch_done), 64'd0);
        for (int c = 2; c <= 5; c++) begin
            @(negedge clk);
            check_gap("sw1");
        end
        @(negedge clk);
        check("sw1_active", 64'(active), 64'b0010);
        check("sw1_done", 64'(switch_done), 64'd1);
        check("sw1_out", 64'(io_out), 64'(mk_out(1)));
        check("sw1_oeb", 64'(io_oeb), 64'(mk_oeb(1)));
        @(negedge clk);
        check("sw1_done_pulse", 64'(switch_done), 64'd0);
        wb_rd("sw1_status", A_STAT, 32'h11);

        // ---- owner 1 -> 3: old owner drops at T+1, 5 quiet cycles ----
        wb_wr(A_CTRL, 32'h83);
        check_gap("sw3_t1");
        for (int c = 2; c <= 5; c++) begin
            @(negedge clk);
            check_gap("sw3");
        end
        @(negedge clk);
        check("sw3_active", 64'(active), 64'b1000);
        check("sw3_done", 64'(switch_done), 64'd1);
        check("sw3_out", 64'(io_out), 64'(mk_out(3)));

        // ---- same owner: no-op ----
        wb_wr(A_CTRL, 32'h83);
        repeat (7) begin
            @(negedge clk);
            check("noop_done", 64'(switch_done), 64'd0);
        end
        check("noop_active", 64'(active), 64'b1000);

        // ---- bad select: ignored, sel_err sticky, W1C ----
        wb_wr(A_CTRL, 32'h85);
        wb_rd("selerr_status", A_STAT, 32'h213);
        wb_rd("selerr_ctrl", A_CTRL, 32'h83);
        check("selerr_active", 64'(active), 64'b1000);
        wb_wr(A_STAT, 32'h200);
        wb_rd("selerr_clr", A_STAT, 32'h13);

        // ---- GUARD=0 stores 1: shortest switch, active at T+3 ----
        wb_wr(A_GUARD, 32'h0);
        wb_rd("guard_zero", A_GUARD, 32'h1);
        wb_wr(A_CTRL, 32'h80);
        check_gap("g1_t1");
        wait_switch("g1", 2, 4'b0001);
        check("g1_out", 64'(io_out), 64'(mk_out(0)));
        wb_wr(A_GUARD, 32'h4);
        wb_rd("guard_4", A_GUARD, 32'h4);

        // ---- CTRL write during GUARD: busy_err, first switch completes ----
        wb_wr(A_CTRL, 32'h81);          // accepted at T, DRAIN at T+1
        wb_wr(A_CTRL, 32'h82);          // accepted at T+2 (GUARD)
        wb_rd("busy_status", A_STAT, 32'h530);  // sampled at T+4
        @(negedge clk);                 // T+6
        check("busy_active", 64'(active), 64'b0010);
        check("busy_done", 64'(switch_done), 64'd1);
        wb_rd("busy_status2", A_STAT, 32'h411);
        wb_rd("busy_ctrl", A_CTRL, 32'h81);
        wb_wr(A_STAT, 32'h400);
        wb_rd("busy_clr", A_STAT, 32'h11);
        wb_rd("swcnt_pre", A_SWCNT, HAS_CNT ? 32'd4 : 32'd0);

        // ---- disable: DRAIN -> GUARD -> IDLE with done pulse ----
        wb_wr(A_CTRL, 32'h01);
        check_gap("dis_t1");
        wait_switch("dis", 5, 4'b0000);
        check("dis_oeb", 64'(io_oeb), 64'(OEB_ALL));
        wb_rd("dis_status", A_STAT, 32'h01);
        wb_wr(A_CTRL, 32'h00);          // disable from IDLE: no-op
        repeat (6) begin
            @(negedge clk);
            check("idle_noop_done", 64'(switch_done), 64'd0);
        end

        // ---- reset mid-switch ----
        wb_wr(A_CTRL, 32'h82);
        @(negedge clk);                 // T+2, GUARD
        rst_n = 1'b0;
        #1;
        check("rst_mid_active", 64'(active), 64'd0);
        check("rst_mid_oeb", 64'(io_oeb), 64'(OEB_ALL));
        check("rst_mid_out", 64'(io_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check("rst_mid_nodone", 64'(switch_done), 64'd0);
            check("rst_mid_idle", 64'(active), 64'd0);
        end
        wb_rd("rst_mid_status", A_STAT, 32'h0);
        wb_rd("rst_mid_guard", A_GUARD, 32'h4);
        wb_rd("rst_mid_swcnt", A_SWCNT, 32'h0);

        // ---- two completed switches, then clear the counter ----
        wb_wr(A_CTRL, 32'h80);
        wait_switch("cnt_a", 5, 4'b0001);
        wb_wr(A_CTRL, 32'h82);
        wait_switch("cnt_b", 5, 4'b0100);
        check("cnt_out", 64'(io_out), 64'(mk_out(2)));
        wb_rd("swcnt_two", A_SWCNT, HAS_CNT ? 32'd2 : 32'd0);
        wb_wr(A_SWCNT, 32'h1234);
        wb_rd("swcnt_clr", A_SWCNT, 32'd0);
        check("cnt_final_active", 64'(active), 64'b0100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/macro_sel_ctrl.md
Name: macro_sel_ctrl

Overview:
Wishbone-configurable owner selector for the user-area test macros that share the IO pads. Only one macro owns io_out/io_oeb at a time, and exactly one macro's active input is asserted.
Ownership changes follow a break-before-make sequence: outputs are tri-stated and all active lines are dropped for a guard interval before the new owner is connected. The block sits in user_project_wrapper between the macros' pad outputs and the top-level io_out/io_oeb.

Parameters:
NUM_MACROS, 4, number of macros sharing the pads (2..8)
IO_W, 38, pad count (MPRJ_IO_PADS)
GUARD_CYCLES, 4, reset value of the guard counter load (1..255)
BASE_ADDR, 32'h3000_0000, Wishbone base address; 16-byte register window

Ports:
wb_clk_i  in  1  clock
wb_rst_ni  in  1  asynchronous active-low reset
wbs_stb_i  in  1  Wishbone strobe
wbs_cyc_i  in  1  Wishbone cycle
wbs_we_i  in  1  write enable
wbs_sel_i  in  4  byte selects; only byte 0 is honoured for CTRL/GUARD writes
wbs_dat_i  in  32  write data
wbs_adr_i  in  32  address
wbs_ack_o  out  1  acknowledge
wbs_dat_o  out  32  read data
io_out_m  in  NUM_MACROS*IO_W  packed macro pad outputs; macro k occupies bits [k*IO_W +: IO_W]
io_oeb_m  in  NUM_MACROS*IO_W  packed macro pad output-enable-bar signals
io_out  out  IO_W  muxed pad outputs
io_oeb  out  IO_W  muxed pad oeb
active  out  NUM_MACROS  one-hot owner enable
switch_done  out  1  one-cycle pulse when a switch completes

Behaviour:
- Reset (wb_rst_ni=0, asynchronous): state=IDLE, owner=0, active=0, io_out=0, io_oeb=all 1, wbs_ack_o=0, wbs_dat_o=0, sticky flags=0, guard load=GUARD_CYCLES, switch_done=0.
- Address decode: a bus cycle hits this block when wbs_adr_i[31:4]==BASE_ADDR[31:4].
  - Offsets: 0x0 CTRL, 0x4 STATUS, 0x8 GUARD, 0xC SWCNT.
  - On a hit with stb&cyc and ack low: wbs_ack_o=1 for exactly one cycle, in the following cycle; wbs_dat_o is valid in that same cycle and is 0 otherwise.
  - No ack is given on a miss.
- CTRL (RW): [7] enable, [2:0] sel. Reads return the last accepted value.
- STATUS:
  - Read-only fields: [2:0] owner, [5:4] state (IDLE=0, ACTIVE=1, DRAIN=2, GUARD=3), [8] busy.
  - [9] sel_err and [10] busy_err are sticky and W1C.
- GUARD (RW): [7:0] guard load. Writing 0 stores 1.
- State machine; all transitions are registered:
  - IDLE: active=0, io_oeb=all 1, io_out=0.
  - ACTIVE: active=1<<owner, io_out=io_out_m slice[owner], io_oeb=io_oeb_m slice[owner] (combinational mux from registered owner).
  - DRAIN: one cycle. Outputs as IDLE. Loads the guard counter.
  - GUARD: outputs as IDLE. Counter decrements each cycle. On reaching 1, transitions to ACTIVE if target enabled, else IDLE, and pulses switch_done.
- CTRL write accepted in cycle T (the ack is in T+1):
  - enable=1, sel<NUM_MACROS, and (state IDLE, or state ACTIVE with sel!=owner): target=sel; DRAIN in T+1, GUARD T+2..T+1+G, new owner active at T+2+G.
  - enable=1, sel==owner, state ACTIVE: no-op, no switch_done.
  - enable=0 from ACTIVE: DRAIN→GUARD→IDLE. enable=0 from IDLE: no-op.
  - sel>=NUM_MACROS: write is ignored, CTRL is unchanged, sel_err is set.
  - Any CTRL write while in DRAIN/GUARD: ignored, busy_err is set; the in-flight switch completes.
- Invariants:
  - popcount(active)<=1 in every cycle.
  - active is never high in DRAIN/GUARD.
  - The old owner drops in the same cycle DRAIN is entered.
- Reset asserted mid-switch: immediately returns to IDLE with all outputs at reset values; no switch_done.
- Simultaneous W1C STATUS write and a new error event in the same cycle: the set wins.

Optional Feature:
SWITCH_COUNT_EN
- Defined: SWCNT[15:0] counts completed switches into ACTIVE. It saturates at 0xFFFF, and any write to SWCNT clears it.
- Undefined: the counter is not built; SWCNT reads 0 and writes to it are acked and ignored.

Test Plan:
- Reset, then read STATUS -> 0x0000_0000; io_oeb=all 1; active=0.
- Write CTRL=0x81 at T with GUARD=4 -> DRAIN at T+1, GUARD T+2..T+5, active=4'b0010 at T+6, switch_done pulse at T+6, io_out equals macro1 slice.
- While owner=1, write CTRL=0x83 -> active goes 0 at T+1 and stays 0 for 5 cycles, then becomes 4'b1000; io_oeb is all 1 throughout the gap.
- Write CTRL=0x85 (sel=5, NUM_MACROS=4) -> owner unchanged, STATUS[9]=1; write STATUS=0x200 -> STATUS[9]=0.
- Write CTRL=0x82 during GUARD -> busy_err=1, original switch completes, owner is the first target.
- Assert wb_rst_ni low during GUARD -> same cycle: active=0, io_oeb=all 1, state IDLE; with SWITCH_COUNT_EN, SWCNT=0 and counts 2 after two completed switches.
